obi_arbiter_2to1: RTL and testbench
===================================

// Module: obi_arbiter_2to1
// PURPOSE
//  Shares one downstream OBI port between two OBI requesters: port 0 is the core instruction fetch and port 1 is core data.
//  Sits between the CV32E40P and the single-beat OBI-to-AXI4 master bridge.
//  Allows one transaction in flight. Adds no latency when the winning request is granted in the same cycle.
// PARAMETERS
//  ADDR_W  32  address width, all ports
//  DATA_W  32  data width, all ports; byte-enable width is DATA_W/8
// PORTS
//  clk           in   1         clock
//  rst_n         in   1         asynchronous active-low reset
//  m0_req_i      in   1         instr request
//  m0_we_i       in   1         instr write enable (normally 0)
//  m0_be_i       in   DATA_W/8  instr byte enables
//  m0_addr_i     in   ADDR_W    instr address
//  m0_wdata_i    in   DATA_W    instr write data
//  m0_gnt_o      out  1         instr grant
//  m0_rvalid_o   out  1         instr response valid
//  m0_rdata_o    out  DATA_W    instr read data
//  m1_*          --   --        data port; identical set to m0_*
//  s_req_o       out  1         downstream request
//  s_we_o / s_be_o / s_addr_o / s_wdata_o  out  --  muxed request fields
//  s_gnt_i       in   1         downstream grant
//  s_rvalid_i    in   1         downstream response; asserted for reads AND writes
//  s_rdata_i     in   DATA_W    downstream read data
// BEHAVIOUR
//  FSM states: IDLE, REQ (owner presented, waiting for gnt), RESP (waiting for rvalid). owner_q is 1 bit.
//  Reset: state=IDLE, owner_q=0, last_q=1 (m0 wins the first tie); all outputs 0.
//  IDLE: if any mX_req_i, pick winner w combinationally and drive s_* from m_w.
//   s_gnt_i=1 -> m_w_gnt_o=1 in the same cycle, owner_q<=w, go to RESP.
//   s_gnt_i=0 -> owner_q<=w, go to REQ.
//  REQ: s_* is driven from owner_q only; the other requester cannot preempt (OBI: req stays stable until gnt).
//   On s_gnt_i: gnt goes to owner, go to RESP.
//  RESP: s_req_o=0. All mX_gnt_o=0.
//   On s_rvalid_i: m_owner_rvalid_o=1, go to IDLE. The next arbitration happens in the following cycle (no back-to-back grant).
//  rdata: s_rdata_i is routed to both ports. Only the owner's rvalid is asserted; the non-owner's rvalid is always 0.
//  s_rvalid_i outside RESP is ignored; an assertion flags this as a protocol error.
//  Reset mid-transaction: abandon immediately, return to IDLE. A late downstream rvalid is ignored.
//  Requester dropping req in REQ (protocol violation): FSM holds; an assertion flags it.
//  last_q is updated to the winner on every grant.
// CONFIGURATION
//  OBI_ARB_RR_EN defined: round-robin. On a tie, the winner is the port != last_q.
//  OBI_ARB_RR_EN undefined: fixed priority, m1 (data) always wins ties. last_q remains present but is unused.
// STRUCTURE
//  obi_arb_pkg: state_e enum {IDLE,REQ,RESP}; PORT_INSTR=1'b0, PORT_DATA=1'b1.
//  One natural sub-module: obi_arb_pick (combinational winner select from req[1:0], last_q, macro).
//   Everything else is flat in obi_arbiter_2to1.
// TESTING
//  1. Only m0 reads 0x0000_0100, slave gnt same cycle, rvalid +2 with 0xDEADBEEF -> m0_gnt at cycle 0, m0_rdata=0xDEADBEEF, m1 sees nothing.
//  2. m0 and m1 both request in the same cycle with RR_EN -> m0 is granted first, then m1. Without RR_EN -> m1 first, then m0.
//  3. m1 writes 0x1000_0004=0x55 with be=0x1, slave gnt delayed 3 cycles; m0 requests during the wait -> s_addr stays 0x1000_0004 until gnt, and m0 is served after m1's rvalid.
//  4. Both ports continuously requesting, RR_EN, 6 transactions -> grants alternate 0,1,0,1,0,1 with no starvation.
//  5. rst_n asserted while in RESP, then a stray s_rvalid_i one cycle after release -> all outputs 0, state IDLE, no mX_rvalid_o pulse.
//  6. Slave gnt and rvalid back-to-back with 1-cycle latency -> no arbitration in the rvalid cycle; throughput is 1 transaction / 3 cycles.

Source files
------------

// File: rtl/obi_arb_pkg.sv
// Shared types and constants for the two-requester OBI arbiter.
package obi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic PORT_INSTR = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/obi_arb_pick.sv
// Combinational winner select for the OBI arbiter.
// OBI_ARB_RR_EN selects round-robin tie-breaking; otherwise the data port wins ties.
module obi_arb_pick
    import obi_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_winner
);

`ifdef OBI_ARB_RR_EN
    // On a tie the port that did not win last time goes next.
    always_comb begin
        if (i_req == 2'b11) begin
            o_winner = ~i_last;
        end else if (i_req[1]) begin
            o_winner = PORT_DATA;
        end else begin
            o_winner = PORT_INSTR;
        end
    end
`else
    logic w_unused_last;

    assign w_unused_last = i_last;
    assign o_winner      = i_req[1] ? PORT_DATA : PORT_INSTR;
`endif

endmodule

// File: rtl/obi_arbiter_2to1.sv
// Two-to-one OBI arbiter (instr fetch on port 0, data on port 1) with one transaction in flight.
// Tie-breaking is round-robin when OBI_ARB_RR_EN is defined, fixed data-first otherwise.
module obi_arbiter_2to1
    import obi_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    output logic                m0_gnt_o,
    output logic                m0_rvalid_o,
    output logic [DATA_W-1:0]   m0_rdata_o,

    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    output logic                m1_gnt_o,
    output logic                m1_rvalid_o,
    output logic [DATA_W-1:0]   m1_rdata_o,

    output logic                s_req_o,
    output logic                s_we_o,
    output logic [DATA_W/8-1:0] s_be_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    input  logic                s_gnt_i,
    input  logic                s_rvalid_i,
    input  logic [DATA_W-1:0]   s_rdata_i
);

    state_e     r_state;
    logic       r_owner;
    logic       r_last;

    logic [1:0] w_req;
    logic       w_winner;
    logic       w_sel;
    logic       w_grant;
    logic       w_resp;

    assign w_req = {m1_req_i, m0_req_i};

    obi_arb_pick u_pick (
        .i_req    (w_req),
        .i_last   (r_last),
        .o_winner (w_winner)
    );

    // Fresh arbitration only in IDLE; once presented, the owner is locked until gnt.
    assign w_sel   = (r_state == IDLE) ? w_winner : r_owner;
    assign s_req_o = (r_state == IDLE) ? (|w_req) :
                     (r_state == REQ)  ? w_req[r_owner] : 1'b0;

    assign s_we_o    = s_req_o & (w_sel ? m1_we_i : m0_we_i);
    assign s_be_o    = s_req_o ? (w_sel ? m1_be_i    : m0_be_i)    : '0;
    assign s_addr_o  = s_req_o ? (w_sel ? m1_addr_i  : m0_addr_i)  : '0;
    assign s_wdata_o = s_req_o ? (w_sel ? m1_wdata_i : m0_wdata_i) : '0;

    assign w_grant  = s_req_o & s_gnt_i;
    assign m0_gnt_o = w_grant & (w_sel == PORT_INSTR);
    assign m1_gnt_o = w_grant & (w_sel == PORT_DATA);

    // Responses are only accepted while waiting for one; anything else is dropped.
    assign w_resp      = (r_state == RESP) & s_rvalid_i;
    assign m0_rvalid_o = w_resp & (r_owner == PORT_INSTR);
    assign m1_rvalid_o = w_resp & (r_owner == PORT_DATA);
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_owner <= PORT_INSTR;
            r_last  <= PORT_DATA;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_owner <= w_winner;
                        if (s_gnt_i) begin
                            r_last  <= w_winner;
                            r_state <= RESP;
                        end else begin
                            r_state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (w_grant) begin
                        r_last  <= r_owner;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    if (s_rvalid_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    // A stray response is tolerated (e.g. a late one after reset), so it only warns.
    a_rvalid_in_resp: assert property (@(posedge clk) disable iff (!rst_n)
        s_rvalid_i |-> (r_state == RESP))
        else $warning("obi_arbiter_2to1: s_rvalid_i outside RESP ignored");

    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == REQ) |-> w_req[r_owner])
        else $error("obi_arbiter_2to1: owner dropped req before gnt");
`endif

endmodule

// File: tb/tb_obi_arbiter_2to1.sv
// Self-checking bench for obi_arbiter_2to1: transaction-level reference model plus scoreboard.
// Expected tie-breaking follows OBI_ARB_RR_EN when it is defined for the build.
module tb_obi_arbiter_2to1;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    localparam int FREE    = 0;
    localparam int PRESENT = 1;
    localparam int WAITR   = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [BE_W-1:0]   m0_be_i, m1_be_i;
    logic [ADDR_W-1:0] m0_addr_i, m1_addr_i;
    logic [DATA_W-1:0] m0_wdata_i, m1_wdata_i;
    logic              m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [DATA_W-1:0] m0_rdata_o, m1_rdata_o;
    logic              s_req_o, s_we_o, s_gnt_i, s_rvalid_i;
    logic [BE_W-1:0]   s_be_o;
    logic [ADDR_W-1:0] s_addr_o;
    logic [DATA_W-1:0] s_wdata_o, s_rdata_i;

    obi_arbiter_2to1 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_addr_o(s_addr_o),
        .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                port;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        int                autoN;
    } cmd_t;

    typedef struct {
        logic              sReq;
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
        logic [1:0]        gnt;
        logic [1:0]        rv;
        int                cyc;
    } snap_t;

    cmd_t              cmdQ[$];
    snap_t             expCycleQ[$];
    logic [DATA_W-1:0] expResp0[$];
    logic [DATA_W-1:0] expResp1[$];
    int                obsOrder[$];
    int                obsCycle[$];

    int                checkCount = 0;
    int                errorCount = 0;

    logic              pend[2];
    logic              rqWe[2];
    logic [BE_W-1:0]   rqBe[2];
    logic [ADDR_W-1:0] rqAddr[2];
    logic [DATA_W-1:0] rqWdata[2];
    int                autoCount[2];
    int                mState = FREE;
    int                mOwner = 0;
    int                mLast = 1;
    int                gntCnt = 0;
    int                rvCnt = 0;
    int                cycNo = 0;

    int                cfgGnt = 0;
    int                cfgRv = 1;
    logic              randMode = 1'b0;
    logic              useDirRdata = 1'b0;
    logic [DATA_W-1:0] dirRdata = '0;
    int                strayCyc = -1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Arbitration rule stated directly: lone requester wins; ties by configured policy.
    function automatic int pickRef(input logic [1:0] reqs, input int last);
        if (reqs == 2'b01) return 0;
        if (reqs == 2'b10) return 1;
`ifdef OBI_ARB_RR_EN
        return 1 - last;
`else
        return 1;
`endif
    endfunction

    task automatic randomReq(input int p);
        pend[p]    = 1'b1;
        rqWe[p]    = 1'($urandom_range(0, 1));
        rqBe[p]    = BE_W'($urandom_range(1, 15));
        rqAddr[p]  = $urandom & 32'hFFFF_FFFC;
        rqWdata[p] = $urandom;
    endtask

    // Requesters, downstream slave and reference model advance together once per cycle.
    always @(negedge clk) begin : stimProc
        snap_t             e;
        cmd_t              c;
        logic              doGnt;
        logic              doRv;
        logic [DATA_W-1:0] rd;
        e.sReq = 1'b0; e.addr = '0; e.we = 1'b0; e.be = '0; e.wdata = '0;
        e.gnt = 2'b00; e.rv = 2'b00; e.cyc = cycNo;
        doGnt = 1'b0; doRv = 1'b0; rd = $urandom;
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                pend[p] = 1'b0; autoCount[p] = 0; rqWe[p] = 1'b0;
                rqBe[p] = '0; rqAddr[p] = '0; rqWdata[p] = '0;
            end
            mState = FREE; mOwner = 0; mLast = 1;
        end else begin
            while (cmdQ.size() > 0) begin
                c = cmdQ.pop_front();
                pend[c.port] = 1'b1; rqWe[c.port] = c.we; rqBe[c.port] = c.be;
                rqAddr[c.port] = c.addr; rqWdata[c.port] = c.wdata; autoCount[c.port] = c.autoN;
            end
            if (mState == FREE && (pend[0] || pend[1])) begin
                mOwner = pickRef({pend[1], pend[0]}, mLast);
                gntCnt = randMode ? int'($urandom_range(0, 3)) : cfgGnt;
                mState = PRESENT;
            end
            if (mState == PRESENT) begin
                e.sReq = 1'b1; e.addr = rqAddr[mOwner]; e.we = rqWe[mOwner];
                e.be = rqBe[mOwner]; e.wdata = rqWdata[mOwner];
                if (gntCnt == 0) begin
                    doGnt = 1'b1; e.gnt[mOwner] = 1'b1; mLast = mOwner;
                    rvCnt = randMode ? int'($urandom_range(1, 3)) : cfgRv;
                    mState = WAITR;
                end else begin
                    gntCnt--;
                end
            end else if (mState == WAITR) begin
                rvCnt--;
                if (rvCnt == 0) begin
                    doRv = 1'b1; e.rv[mOwner] = 1'b1;
                    rd = useDirRdata ? dirRdata : $urandom;
                    if (mOwner == 0) expResp0.push_back(rd);
                    else             expResp1.push_back(rd);
                    mState = FREE;
                end
            end
            if (cycNo == strayCyc && mState == FREE) doRv = 1'b1;
        end
        m0_req_i = pend[0]; m0_we_i = rqWe[0]; m0_be_i = rqBe[0];
        m0_addr_i = rqAddr[0]; m0_wdata_i = rqWdata[0];
        m1_req_i = pend[1]; m1_we_i = rqWe[1]; m1_be_i = rqBe[1];
        m1_addr_i = rqAddr[1]; m1_wdata_i = rqWdata[1];
        s_gnt_i = doGnt; s_rvalid_i = doRv; s_rdata_i = rd;
        if (rst_n) begin
            if (doGnt) begin
                pend[mOwner] = 1'b0;
                if (autoCount[mOwner] > 0) begin
                    autoCount[mOwner]--;
                    randomReq(mOwner);
                end
            end
            if (randMode) begin
                for (int p = 0; p < 2; p++)
                    if (!pend[p] && $urandom_range(0, 2) == 0) randomReq(p);
            end
        end
        expCycleQ.push_back(e);
        cycNo++;
    end

    // Monitor: compares presented outputs against the model's expectations for the same cycle.
    always @(negedge clk) begin : monProc
        snap_t e;
        #3;
        if (expCycleQ.size() == 0) begin
            checkOutput("cycleQueue", 64'(0), 64'(1));
        end else begin
            e = expCycleQ.pop_front();
            checkOutput("sReq", 64'(s_req_o), 64'(e.sReq));
            if (e.sReq) begin
                checkOutput("sAddr", 64'(s_addr_o), 64'(e.addr));
                checkOutput("sWe", 64'(s_we_o), 64'(e.we));
                checkOutput("sBe", 64'(s_be_o), 64'(e.be));
                checkOutput("sWdata", 64'(s_wdata_o), 64'(e.wdata));
            end
            checkOutput("grant", 64'({m1_gnt_o, m0_gnt_o}), 64'(e.gnt));
            checkOutput("rvalid", 64'({m1_rvalid_o, m0_rvalid_o}), 64'(e.rv));
            if (m0_gnt_o || m1_gnt_o) begin
                obsOrder.push_back(m1_gnt_o ? 1 : 0);
                obsCycle.push_back(e.cyc);
            end
        end
        if (m0_rvalid_o) begin
            if (expResp0.size() == 0) checkOutput("spuriousRvalid0", 64'(1), 64'(0));
            else checkOutput("rdata0", 64'(m0_rdata_o), 64'(expResp0.pop_front()));
        end
        if (m1_rvalid_o) begin
            if (expResp1.size() == 0) checkOutput("spuriousRvalid1", 64'(1), 64'(0));
            else checkOutput("rdata1", 64'(m1_rdata_o), 64'(expResp1.pop_front()));
        end
    end

    task automatic applyStimulus(input int port, input logic we, input logic [BE_W-1:0] be,
                                 input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                                 input int autoN);
        cmd_t c;
        c.port = port; c.we = we; c.be = be; c.addr = addr; c.wdata = wdata; c.autoN = autoN;
        cmdQ.push_back(c);
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        strayCyc = -1; useDirRdata = 1'b0; randMode = 1'b0;
        expResp0.delete(); expResp1.delete(); cmdQ.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        obsOrder.delete(); obsCycle.delete();
    endtask

    task automatic waitQuiet(input int limit);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!(mState == FREE && !pend[0] && !pend[1] && cmdQ.size() == 0 &&
                     autoCount[0] == 0 && autoCount[1] == 0) && n < limit);
        checkOutput("quietTimeout", 64'(n >= limit), 64'(0));
    endtask

    // Grant order is packed LSB-first: bit i is the port of the i-th grant.
    task automatic checkOrder(input string name, input int n, input logic [7:0] bits);
        checkOutput({name, "Len"}, 64'(obsOrder.size()), 64'(n));
        for (int i = 0; i < n && i < obsOrder.size(); i++)
            checkOutput(name, 64'(obsOrder[i]), 64'(bits[i]));
    endtask

    initial begin : mainProc
        int issueCyc;
        $display("[TB] start");
        doReset();
        checkOutput("rstSReq", 64'(s_req_o), 64'(0));
        checkOutput("rstGnt", 64'({m1_gnt_o, m0_gnt_o}), 64'(0));

        // Lone instruction read, same-cycle grant, response two cycles later.
        cfgGnt = 0; cfgRv = 2; useDirRdata = 1'b1; dirRdata = 32'hDEAD_BEEF;
        issueCyc = cycNo;
        applyStimulus(0, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 0);
        waitQuiet(50);
        checkOrder("t1Order", 1, 8'b0);
        if (obsCycle.size() > 0) checkOutput("t1GntCycle", 64'(obsCycle[0]), 64'(issueCyc));

        // Simultaneous requests.
        doReset();
        cfgGnt = 0; cfgRv = 1;
        applyStimulus(0, 1'b0, 4'hF, 32'h0000_0200, 32'h0, 0);
        applyStimulus(1, 1'b0, 4'hF, 32'h1000_0000, 32'h0, 0);
        waitQuiet(50);
`ifdef OBI_ARB_RR_EN
        checkOrder("t2Order", 2, 8'b10);
`else
        checkOrder("t2Order", 2, 8'b01);
`endif

        // Data write with slow grant; instr request arrives mid-wait and must not preempt.
        doReset();
        cfgGnt = 3; cfgRv = 1;
        applyStimulus(1, 1'b1, 4'h1, 32'h1000_0004, 32'h55, 0);
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 4'hF, 32'h0000_0300, 32'h0, 0);
        waitQuiet(80);
        checkOrder("t3Order", 2, 8'b01);

        // Both ports requesting continuously, three transactions each.
        doReset();
        cfgGnt = 0; cfgRv = 1;
        applyStimulus(0, 1'b0, 4'hF, 32'h0000_0400, 32'h0, 2);
        applyStimulus(1, 1'b0, 4'hF, 32'h1000_0400, 32'h0, 2);
        waitQuiet(100);
`ifdef OBI_ARB_RR_EN
        checkOrder("t4Order", 6, 8'b101010);
`else
        checkOrder("t4Order", 6, 8'b000111);
`endif

        // Reset while waiting for a response, then a stray late rvalid.
        doReset();
        cfgGnt = 0; cfgRv = 10;
        applyStimulus(0, 1'b0, 4'hF, 32'h0000_0500, 32'h0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk); #4;
        checkOutput("t5SReq", 64'(s_req_o), 64'(0));
        checkOutput("t5SAddr", 64'(s_addr_o), 64'(0));
        checkOutput("t5SWe", 64'({s_we_o, s_be_o}), 64'(0));
        checkOutput("t5SWdata", 64'(s_wdata_o), 64'(0));
        checkOutput("t5MOut", 64'({m1_gnt_o, m0_gnt_o, m1_rvalid_o, m0_rvalid_o}), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        obsOrder.delete(); obsCycle.delete();
        strayCyc = cycNo;
        repeat (2) @(posedge clk);
        #1;
        cfgGnt = 0; cfgRv = 1;
        issueCyc = cycNo;
        applyStimulus(1, 1'b0, 4'hF, 32'h1000_0500, 32'h0, 0);
        waitQuiet(50);
        checkOrder("t5Order", 1, 8'b1);
        if (obsCycle.size() > 0) checkOutput("t5GntCycle", 64'(obsCycle[0]), 64'(issueCyc));

        // One-cycle grant and response latency: one transaction every three cycles.
        doReset();
        cfgGnt = 1; cfgRv = 1;
        applyStimulus(0, 1'b0, 4'hF, 32'h0000_0600, 32'h0, 3);
        waitQuiet(60);
        checkOrder("t6Order", 4, 8'b0);
        for (int i = 1; i < obsCycle.size(); i++)
            checkOutput("t6Spacing", 64'(obsCycle[i] - obsCycle[i-1]), 64'(3));

        // Randomized traffic with random slave latencies.
        doReset();
        randMode = 1'b1;
        repeat (400) @(posedge clk);
        #1;
        randMode = 1'b0;
        waitQuiet(50);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("leftResp0", 64'(expResp0.size()), 64'(0));
        checkOutput("leftResp1", 64'(expResp1.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin : watchdog
        #200000;
        errorCount++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
